// File: rtl/mc_reg_array_if.sv
// Signal bundle between the macrocell logic/pin model and the mc_reg_array storage bank.
// The master side drives the cell controls and readback strobes; the slave side is the register bank.
interface mc_reg_array_if #(
  parameter int N_MC = 16
);
  logic [2*N_MC-1:0] storage_mode;
  logic [N_MC-1:0]   ffd;
  logic [N_MC-1:0]   ffen;
  logic [N_MC-1:0]   ffas;
  logic [N_MC-1:0]   ffar;
  logic [N_MC-1:0]   o_mux;
  logic [N_MC-1:0]   oe;
  logic [N_MC-1:0]   ffq;
  logic [N_MC-1:0]   ffqn;
  logic [N_MC-1:0]   pin_q;
  logic [N_MC-1:0]   pin_oe;
  logic              rb_capture;
  logic              rb_shift;
  logic              rb_sdo;
  logic              rb_busy;

  modport master (
    output storage_mode, ffd, ffen, ffas, ffar, o_mux, oe, rb_capture, rb_shift,
    input  ffq, ffqn, pin_q, pin_oe, rb_sdo, rb_busy
  );

  modport slave (
    input  storage_mode, ffd, ffen, ffas, ffar, o_mux, oe, rb_capture, rb_shift,
    output ffq, ffqn, pin_q, pin_oe, rb_sdo, rb_busy
  );
endinterface

// File: rtl/mc_reg_array.sv
// Bank of N_MC macrocell registers (D / T / bypass) with pin output muxing and a
// serial readback chain that snapshots every register for state dumps.
//
// state    | meaning
// RB_IDLE  | no snapshot held; rb_capture loads the shadow from ffq
// RB_SHIFT | snapshot held; rb_shift presents the next cell on rb_sdo
module mc_reg_array #(
  parameter int              N_MC   = 16,
  parameter logic [N_MC-1:0] INIT_Q = '0
) (
  input logic            gclk,
  input logic            gclr,
  mc_reg_array_if.slave  bus
);

  localparam int CW = $clog2(N_MC + 1);

  typedef enum logic {
    RB_IDLE  = 1'b0,
    RB_SHIFT = 1'b1
  } rb_state_e;

  logic [N_MC-1:0] ffq_q, ffq_d;
  logic [N_MC-1:0] bypass;
  logic [N_MC-1:0] shadow_q, shadow_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  rb_state_e       state_q, state_d;

  // Set/reset take priority over the clock enable; bypass freezes only the data path.
  always_comb begin
    ffq_d  = ffq_q;
    bypass = '0;
    for (int i = 0; i < N_MC; i++) begin
      bypass[i] = (bus.storage_mode[2*i +: 2] == 2'b10);
      if (bus.ffar[i]) begin
        ffq_d[i] = 1'b0;
      end else if (bus.ffas[i]) begin
        ffq_d[i] = 1'b1;
      end else if (bus.ffen[i]) begin
        unique case (bus.storage_mode[2*i +: 2])
          2'b01:   ffq_d[i] = ffq_q[i] ^ bus.ffd[i];
          2'b10:   ffq_d[i] = ffq_q[i];
          default: ffq_d[i] = bus.ffd[i];
        endcase
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      RB_IDLE: begin
        if (bus.rb_capture) begin
          shadow_d = ffq_q;
          cnt_d    = CW'(N_MC);
          state_d  = RB_SHIFT;
        end
      end
      RB_SHIFT: begin
        if (bus.rb_shift) begin
          shadow_d = shadow_q >> 1;
          cnt_d    = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = RB_IDLE;
          end
        end
      end
      default: state_d = RB_IDLE;
    endcase
  end

  always_ff @(posedge gclk or posedge gclr) begin
    if (gclr) begin
      ffq_q    <= INIT_Q;
      shadow_q <= '0;
      cnt_q    <= '0;
      state_q  <= RB_IDLE;
    end else begin
      ffq_q    <= ffq_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
    end
  end

  // pin_q is deliberately not gated by oe; tri-state lives in the pin model.
  assign bus.ffq     = ffq_q;
  assign bus.ffqn    = ~ffq_q;
  assign bus.pin_q   = ((bus.o_mux | bypass) & bus.ffd) | (~(bus.o_mux | bypass) & ffq_q);
  assign bus.pin_oe  = bus.oe;
  assign bus.rb_busy = (state_q == RB_SHIFT);
  assign bus.rb_sdo  = (state_q == RB_SHIFT) & shadow_q[0];

endmodule

// File: tb/tb_mc_reg_array.sv
// Directed bench for mc_reg_array (N_MC=4, INIT_Q=1010): a bit-level model checked every
// negedge plus hand-computed literal expectations at the interesting points.
module tb_mc_reg_array;
  localparam int          N    = 4;
  localparam logic [3:0]  INIT = 4'b1010;

  logic gclk = 1'b0;
  logic gclr = 1'b0;
  always #5 gclk = ~gclk;

  mc_reg_array_if #(.N_MC(N)) bus ();

  mc_reg_array #(.N_MC(N), .INIT_Q(INIT)) dut (
    .gclk (gclk),
    .gclr (gclr),
    .bus  (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  // Model: register bits, plus a snapshot with a read position for readback.
  logic [3:0] m_q;
  logic [3:0] m_snap;
  int         m_pos;
  bit         m_act;

  function automatic logic next_bit(input int i);
    logic [1:0] md;
    md = bus.storage_mode[2*i +: 2];
    if (bus.ffar[i]) return 1'b0;
    if (bus.ffas[i]) return 1'b1;
    if (!bus.ffen[i]) return m_q[i];
    if (md == 2'b01) return m_q[i] ^ bus.ffd[i];
    if (md == 2'b10) return m_q[i];
    return bus.ffd[i];
  endfunction

  always @(posedge gclk or posedge gclr) begin
    if (gclr) begin
      m_q    <= INIT;
      m_snap <= '0;
      m_pos  <= 0;
      m_act  <= 1'b0;
    end else begin
      if (!m_act) begin
        if (bus.rb_capture) begin
          m_snap <= m_q;
          m_pos  <= 0;
          m_act  <= 1'b1;
        end
      end else if (bus.rb_shift) begin
        if (m_pos == N - 1) m_act <= 1'b0;
        m_pos <= m_pos + 1;
      end
      for (int i = 0; i < N; i++) m_q[i] <= next_bit(i);
    end
  end

  always @(negedge gclk) begin
    if (chk_en) begin
      logic [3:0] exp_pin;
      for (int i = 0; i < N; i++)
        exp_pin[i] = (bus.o_mux[i] || bus.storage_mode[2*i +: 2] == 2'b10) ? bus.ffd[i] : m_q[i];
      chk("cyc_ffq",    {4'b0, bus.ffq},    {4'b0, m_q});
      chk("cyc_ffqn",   {4'b0, bus.ffqn},   {4'b0, ~m_q});
      chk("cyc_pin_q",  {4'b0, bus.pin_q},  {4'b0, exp_pin});
      chk("cyc_pin_oe", {4'b0, bus.pin_oe}, {4'b0, bus.oe});
      chk("cyc_busy",   {7'b0, bus.rb_busy}, {7'b0, m_act});
      chk("cyc_sdo",    {7'b0, bus.rb_sdo},  {7'b0, (m_act ? m_snap[m_pos] : 1'b0)});
    end
  end

  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  initial begin
    logic [3:0] sdo_exp;
    bus.storage_mode = '0;
    bus.ffd = '0; bus.ffen = '0; bus.ffas = '0; bus.ffar = '0;
    bus.o_mux = '0; bus.oe = '0;
    bus.rb_capture = 1'b0; bus.rb_shift = 1'b0;

    // Mid-cycle clear, no clock edge involved
    #23 gclr = 1'b1;
    #1;
    chk("clr_ffq",  {4'b0, bus.ffq},  8'b0000_1010);
    chk("clr_ffqn", {4'b0, bus.ffqn}, 8'b0000_0101);
    chk("clr_busy", {7'b0, bus.rb_busy}, 8'd0);
    tick();
    gclr = 1'b0;
    chk_en = 1'b1;

    // D mode load and enable hold
    bus.ffen = 4'b0001; bus.ffd = 4'b0001; tick();
    chk("d_load", {4'b0, bus.ffq}, 8'b0000_1011);
    bus.ffen = 4'b0000; bus.ffd = 4'b0000; tick();
    chk("d_hold", {4'b0, bus.ffq}, 8'b0000_1011);

    // T mode from 0: 1,0,1 then hold
    bus.ffar = 4'b0010; tick();
    chk("t_clear", {4'b0, bus.ffq}, 8'b0000_1001);
    bus.ffar = 4'b0000; bus.storage_mode = 8'b0000_0100;
    bus.ffen = 4'b0010; bus.ffd = 4'b0010;
    tick(); chk("t_seq0", {7'b0, bus.ffq[1]}, 8'd1);
    tick(); chk("t_seq1", {7'b0, bus.ffq[1]}, 8'd0);
    tick(); chk("t_seq2", {7'b0, bus.ffq[1]}, 8'd1);
    bus.ffd = 4'b0000; tick();
    chk("t_hold", {4'b0, bus.ffq}, 8'b0000_1011);

    // Set/reset priority, ignoring ffen
    bus.ffen = 4'b0000; bus.ffas = 4'b0100; tick();
    chk("set", {4'b0, bus.ffq}, 8'b0000_1111);
    bus.ffar = 4'b0100; tick();
    chk("ar_wins", {4'b0, bus.ffq}, 8'b0000_1011);
    bus.ffar = 4'b0000; tick();
    chk("set_again", {4'b0, bus.ffq}, 8'b0000_1111);

    // Bypass: register frozen, pin follows ffd
    bus.ffas = 4'b0000; bus.storage_mode = 8'b0010_0100; bus.ffen = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      bus.ffd = (k % 2 == 0) ? 4'b0000 : 4'b0100;
      #1;
      chk("byp_pin", {7'b0, bus.pin_q[2]}, {7'b0, bus.ffd[2]});
      tick();
      chk("byp_ffq", {7'b0, bus.ffq[2]}, 8'd1);
    end

    // Output mux in D mode
    bus.storage_mode = 8'b0000_0000; bus.ffen = 4'b0000; bus.o_mux = 4'b0000;
    bus.ffd = 4'b0100; bus.oe = 4'b0110;
    #1;
    chk("pin_reg", {4'b0, bus.pin_q}, 8'b0000_1111);
    chk("pin_oe",  {4'b0, bus.pin_oe}, 8'b0000_0110);
    bus.o_mux = 4'b0001; bus.ffd = 4'b0000;
    #1;
    chk("pin_comb", {4'b0, bus.pin_q}, 8'b0000_1110);
    tick();

    // Mode 11 behaves as D
    bus.o_mux = 4'b0000; bus.storage_mode = 8'b1100_0000; bus.ffen = 4'b1000; tick();
    chk("mode11_d", {4'b0, bus.ffq}, 8'b0000_0111);

    // Readback of 0110 with ffd changing on the capture edge
    bus.storage_mode = '0; bus.ffen = 4'b0000;
    bus.ffar = 4'b1001; bus.ffas = 4'b0110; tick();
    chk("pre_rb", {4'b0, bus.ffq}, 8'b0000_0110);
    bus.ffar = 4'b0000; bus.ffas = 4'b0000;
    bus.ffen = 4'b1111; bus.ffd = 4'b1111; bus.rb_capture = 1'b1; tick();
    chk("cap_ffq",  {4'b0, bus.ffq}, 8'b0000_1111);
    chk("cap_busy", {7'b0, bus.rb_busy}, 8'd1);
    chk("rb_sdo0",  {7'b0, bus.rb_sdo}, 8'd0);
    bus.ffen = 4'b0000; bus.rb_shift = 1'b1;
    sdo_exp = 4'b0110;
    for (int k = 0; k < 4; k++) begin
      bus.rb_capture = (k == 1);
      tick();
      if (k < 3) begin
        chk("rb_busy_mid", {7'b0, bus.rb_busy}, 8'd1);
        chk("rb_sdo",      {7'b0, bus.rb_sdo}, {7'b0, sdo_exp[k+1]});
      end else begin
        chk("rb_busy_end", {7'b0, bus.rb_busy}, 8'd0);
        chk("rb_sdo_end",  {7'b0, bus.rb_sdo}, 8'd0);
      end
    end
    chk("rb_ffq", {4'b0, bus.ffq}, 8'b0000_1111);
    bus.rb_capture = 1'b0; bus.rb_shift = 1'b0; tick();

    // Capture and shift together: capture wins; shift=0 holds
    bus.rb_capture = 1'b1; bus.rb_shift = 1'b1; tick();
    chk("capshift_busy", {7'b0, bus.rb_busy}, 8'd1);
    chk("capshift_sdo",  {7'b0, bus.rb_sdo}, 8'd1);
    bus.rb_capture = 1'b0; bus.rb_shift = 1'b0; tick(); tick();
    chk("hold_busy", {7'b0, bus.rb_busy}, 8'd1);
    bus.rb_shift = 1'b1; tick(); tick();
    bus.rb_shift = 1'b0;

    // Abort by clear after 2 shifts
    #3 gclr = 1'b1;
    #1;
    chk("abort_busy", {7'b0, bus.rb_busy}, 8'd0);
    chk("abort_sdo",  {7'b0, bus.rb_sdo}, 8'd0);
    chk("abort_ffq",  {4'b0, bus.ffq}, 8'b0000_1010);
    tick();
    gclr = 1'b0;
    bus.rb_shift = 1'b1; tick();
    chk("shift_idle", {7'b0, bus.rb_busy}, 8'd0);
    bus.rb_shift = 1'b0; bus.rb_capture = 1'b1; tick();
    chk("recap_busy", {7'b0, bus.rb_busy}, 8'd1);
    chk("recap_sdo0", {7'b0, bus.rb_sdo}, 8'd0);
    bus.rb_capture = 1'b0; bus.rb_shift = 1'b1;
    sdo_exp = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k < 3) begin
        chk("recap_busy_mid", {7'b0, bus.rb_busy}, 8'd1);
        chk("recap_sdo",      {7'b0, bus.rb_sdo}, {7'b0, sdo_exp[k+1]});
      end else begin
        chk("recap_busy_end", {7'b0, bus.rb_busy}, 8'd0);
      end
    end
    bus.rb_shift = 1'b0;
    tick(); tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
